mult_4x4: RTL and testbench

- Unsigned 4-bit x 4-bit multiplier with a registered 8-bit product.
- Leaf arithmetic block; the sequential 8x8 multiplier datapath uses it to form 4x4 partial products of nibble pairs, which are then shifted and accumulated.
- Internally a shift-and-add array: AND-gate partial products feed ripple-carry adder rows, and the result is captured in an output register.

---
 rtl/mult_4x4.sv | 50 +++++
 tb/tb_mult_4x4.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_4x4.sv
// Unsigned 4x4 shift-and-add array multiplier with a registered 8-bit product.
// AND-gate partial product rows are summed by three 4-bit ripple-carry stages.
module mult_4x4 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] dataam,
  input  logic [3:0] databm,
  output logic [7:0] product
);

  logic [3:0] row [4];
  logic [7:0] comb_product;

  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

  // Stage k adds row k to the upper bits of the running sum and retires one product bit.
  always_comb begin
    logic [3:0] acc;
    logic [3:0] sum;
    logic       carry;
    for (int i = 0; i < 4; i++) begin
      row[i] = databm[i] ? dataam : 4'b0000;
    end
    comb_product    = 8'h00;
    comb_product[0] = row[0][0];
    acc             = {1'b0, row[0][3:1]};
    sum             = 4'b0000;
    carry           = 1'b0;
    for (int k = 1; k < 4; k++) begin
      carry = 1'b0;
      for (int j = 0; j < 4; j++) begin
        {carry, sum[j]} = full_add(row[k][j], acc[j], carry);
      end
      comb_product[k] = sum[0];
      acc             = {carry, sum[3:1]};
    end
    comb_product[7:4] = acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      product <= 8'h00;
    end else begin
      product <= comb_product;
    end
  end

endmodule

// File: tb/tb_mult_4x4.sv
// Self-checking bench for mult_4x4: directed, corner, exhaustive, random and async-reset scenarios.
// Inputs change on the falling edge; outputs are sampled on the falling edge or between edges.
module tb_mult_4x4;

  logic       clk;
  logic       reset_n;
  logic [3:0] dataam;
  logic [3:0] databm;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

  mult_4x4 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dataam  (dataam),
    .databm  (databm),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    int p;
    p = int'(a) * int'(b);
    return p[7:0];
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    dataam  = 4'h3;
    databm  = 4'h4;
    #1;
    checks++;
    if (product !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_async got %h want 00", product);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (product !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d got %h want 00", i, product);
      end
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (product !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_release_pre_edge got %h want 00", product);
    end
    @(negedge clk);
    checks++;
    if (product !== 8'h0C) begin
      errors++;
      $display("[TB] FAIL reset_first_capture got %h want 0c", product);
    end
  endtask

  task automatic test_directed();
    logic [3:0] as [4] = '{4'd3, 4'd12, 4'd10, 4'd14};
    logic [3:0] bs [4] = '{4'd4, 4'd6,  4'd12, 4'd1};
    logic [7:0] want [4] = '{8'h0C, 8'h48, 8'h78, 8'h0E};
    logic [7:0] prev;
    @(negedge clk);
    prev = product;
    for (int i = 0; i < 4; i++) begin
      dataam = as[i];
      databm = bs[i];
      #1;
      checks++;
      if (product !== prev) begin
        errors++;
        $display("[TB] FAIL directed_latency %0d*%0d early got %h want %h", as[i], bs[i], product, prev);
      end
      @(negedge clk);
      checks++;
      if (product !== want[i]) begin
        errors++;
        $display("[TB] FAIL directed %0d*%0d got %h want %h", as[i], bs[i], product, want[i]);
      end
      @(negedge clk);
      checks++;
      if (product !== want[i]) begin
        errors++;
        $display("[TB] FAIL directed_hold %0d*%0d got %h want %h", as[i], bs[i], product, want[i]);
      end
      prev = want[i];
    end
  endtask

  task automatic test_corners();
    logic [3:0] as [5] = '{4'd0, 4'd9, 4'd15, 4'd1,  4'd8};
    logic [3:0] bs [5] = '{4'd9, 4'd0, 4'd15, 4'd15, 4'd8};
    logic [7:0] want [5] = '{8'h00, 8'h00, 8'hE1, 8'h0F, 8'h40};
    for (int i = 0; i < 5; i++) begin
      dataam = as[i];
      databm = bs[i];
      @(negedge clk);
      checks++;
      if (product !== want[i]) begin
        errors++;
        $display("[TB] FAIL corner %0d*%0d got %h want %h", as[i], bs[i], product, want[i]);
      end
    end
    for (int x = 0; x < 16; x++) begin
      dataam = 4'd1;
      databm = 4'(x);
      @(negedge clk);
      checks++;
      if (product !== {4'h0, 4'(x)}) begin
        errors++;
        $display("[TB] FAIL identity 1*%0d got %h want %h", x, product, {4'h0, 4'(x)});
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] expected;
    expected = 8'h00;
    for (int i = 0; i < 256; i++) begin
      dataam = 4'(i >> 4);
      databm = 4'(i & 15);
      @(negedge clk);
      expected = ref_mul(4'(i >> 4), 4'(i & 15));
      checks++;
      if (product !== expected) begin
        errors++;
        $display("[TB] FAIL exhaustive %0d*%0d got %h want %h", i >> 4, i & 15, product, expected);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pending [$];
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] expected;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      a = 4'($urandom_range(15));
      b = 4'($urandom_range(15));
      dataam = a;
      databm = b;
      pending.push_back(ref_mul(a, b));
      @(negedge clk);
      expected = pending.pop_front();
      checks++;
      if (product !== expected) begin
        errors++;
        $display("[TB] FAIL random %0d*%0d got %h want %h", a, b, product, expected);
      end
    end
  endtask

  task automatic test_reset_midstream();
    dataam = 4'd10;
    databm = 4'd12;
    @(negedge clk);
    checks++;
    if (product !== 8'h78) begin
      errors++;
      $display("[TB] FAIL midstream_setup got %h want 78", product);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (product !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midstream_async_clear got %h want 00", product);
    end
    dataam = 4'd5;
    databm = 4'd7;
    @(negedge clk);
    checks++;
    if (product !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midstream_hold got %h want 00", product);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (product !== 8'h23) begin
      errors++;
      $display("[TB] FAIL midstream_release got %h want 23", product);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    dataam  = 4'h0;
    databm  = 4'h0;
    test_reset();
    test_directed();
    test_corners();
    test_exhaustive();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
